fft_bitrev_reorder: RTL
=======================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage directly downstream of the 64-point SDF FFT pipeline and the complex-conjugate stage.
- Accepts complex samples arriving in bit-reversed order, buffers them in a ping-pong memory, and emits each frame in natural order as a contiguous burst.
- Optionally applies the 1/N IFFT normalisation, completing the conjugate-based IFFT path.

Parameters:
- DATA_WIDTH, 32, width of each real/imag component (signed two's complement).
- N, 64, frame length (power of two).
- LOG2N, 6, log2(N); must equal $clog2(N).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  data_in_r/data_in_i carry a sample this cycle.
- data_in_r  input  DATA_WIDTH  signed real part, bit-reversed frame order.
- data_in_i  input  DATA_WIDTH  signed imaginary part.
- out_valid  output  1  data_out_* valid.
- data_out_r  output  DATA_WIDTH  signed real part, natural order.
- data_out_i  output  DATA_WIDTH  signed imaginary part.
- out_index  output  LOG2N  natural-order bin index of current output.
- out_sof  output  1  high with bin 0 of each output frame.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid, out_sof, data_out_r, data_out_i and out_index clear to 0.
  - wr_cnt = 0, wr_bank = 0, read FSM = IDLE.
  - Memory contents are not cleared.
  - A partial input frame is discarded; an in-progress output burst stops immediately.
- Write side:
  - Each clk edge with in_valid = 1 writes the sample to bank[wr_bank] at address bitrev(wr_cnt), then increments wr_cnt modulo N.
  - Gaps (in_valid = 0) are allowed anywhere; there is no backpressure.
- Frame completion:
  - Occurs on the edge that accepts the sample with wr_cnt = N-1.
  - On that edge: wr_cnt wraps to 0, rd_bank <= wr_bank, wr_bank toggles, and the FSM enters READ with rd_cnt = 0.
- Read FSM:
  - IDLE: outputs hold out_valid = 0; data_out_* hold their last value.
  - READ: each edge registers bank[rd_bank][rd_cnt] onto data_out_*, sets out_valid = 1, out_index = rd_cnt, and out_sof = (rd_cnt == 0), then increments rd_cnt.
  - After rd_cnt = N-1 is issued, the FSM returns to IDLE unless a frame completes on the same edge.
- Simultaneous event: if a frame completes on the edge where rd_cnt = N-1 is issued, the FSM stays in READ with rd_cnt = 0 on the new bank. Output is gap-free, N samples back-to-back per frame.
- Latency: bin 0 appears on the outputs after the 2nd rising edge following the edge that accepted the last input sample of the frame. The burst lasts exactly N consecutive cycles.
- Bank conflict is impossible: a frame needs at least N input cycles and a burst lasts exactly N cycles.
- Data path is pass-through (no arithmetic) unless the optional feature is enabled.

Optional Feature:
- Macro: FFT_IFFT_SCALE_EN.
- Defined: each output component = (x + 2^(LOG2N-1)) >>> LOG2N, computed in DATA_WIDTH+1 bits.
  - Rounding is round-half-up.
  - The result is saturated to the signed DATA_WIDTH range; in practice it cannot exceed the range after the shift, but the clamp is kept for safety.
  - Adds no extra latency; the scaling is combinational before the output register.
- Undefined: outputs are raw stored values with no scaling.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N = 64 and FFT_LOG2N = 6.
  - Default DATA_WIDTH.
  - Function bitrev(idx, LOG2N).
  - Typedef for complex sample {re, im}.
- Sub-module fft_pingpong_ram: two N x 2*DATA_WIDTH banks with one write port (bank select + address) and one synchronous read port (bank select + address).

Test Plan:
- Reset, then 64 consecutive in_valid cycles with input n carrying re = bitrev(n), im = -bitrev(n):
  - out_valid rises 2 cycles after the last input.
  - out_index 0..63 appear with re = k, im = -k.
  - out_sof high only at k = 0.
- Same frame with in_valid toggled 1/0 (128 cycles):
  - Output identical to the previous scenario, still contiguous 64 cycles.
- Three back-to-back frames with no gaps:
  - 192 contiguous out_valid cycles.
  - out_sof at cycles 0, 64 and 128 of the burst.
  - Each frame's data is correct, with no bank corruption.
- Assert rst low after 40 input samples, release, then send a full frame:
  - No output from the partial frame.
  - The new frame emerges correctly.
  - All outputs are 0 while reset is held.
- Assert rst low mid-burst at bin 20:
  - out_valid drops asynchronously.
  - No further output until a new full frame arrives.
- With FFT_IFFT_SCALE_EN defined, inputs re = 64, 95, 96, -1, -32, 2^31-1:
  - Outputs 1, 1, 2, 0, 0, 33554432 (the last without saturation fault).
  - Without the macro, outputs equal the inputs.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage: frame geometry, read FSM states,
// complex sample type and the bit-reversal helper.
package fft_pkg;

    localparam int FFT_N          = 64;
    localparam int FFT_LOG2N      = 6;
    localparam int FFT_DATA_WIDTH = 32;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } fft_cplx_t;

    // Reverses the low log2n bits of idx; bits above log2n come back as zero.
    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx,
                                                    input int log2n);
        logic [FFT_LOG2N-1:0] r;
        logic [FFT_LOG2N-1:0] tmp;
        r   = '0;
        tmp = idx;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            if (b < log2n) begin
                r   = {r[FFT_LOG2N-2:0], tmp[0]};
                tmp = tmp >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for fft_bitrev_reorder: bit-reversed input side, natural-order
// output side and the read FSM state for observation.
interface fft_bitrev_reorder_if
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int LOG2N      = FFT_LOG2N
) ();

    // Valid-only streams: a sample transfers on every rising edge where its valid is high;
    // there is no ready, so the consumer must accept every valid beat.
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] data_in_r;
    logic signed [DATA_WIDTH-1:0] data_in_i;

    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] data_out_r;
    logic signed [DATA_WIDTH-1:0] data_out_i;
    logic [LOG2N-1:0]             out_index;
    logic                         out_sof;

    rd_state_t                    dbg_state;

    modport master (
        output in_valid, data_in_r, data_in_i,
        input  out_valid, data_out_r, data_out_i, out_index, out_sof, dbg_state
    );

    modport slave (
        input  in_valid, data_in_r, data_in_i,
        output out_valid, data_out_r, data_out_i, out_index, out_sof, dbg_state
    );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer: one write port and one registered read port, each with its own
// bank select. Contents are never reset.
module fft_pingpong_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 64,
    parameter int LOG2N      = 6
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    wr_bank,
    input  logic [LOG2N-1:0]        wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic                    rd_bank,
    input  logic [LOG2N-1:0]        rd_addr,
    output logic [2*DATA_WIDTH-1:0] rd_data
);

    logic [2*DATA_WIDTH-1:0] mem [0:2*N-1];
    logic [2*DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[{rd_bank, rd_addr}];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder with ping-pong buffering.
// Optional 1/N output scaling with round-half-up when FFT_IFFT_SCALE_EN is defined.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int N          = FFT_N,
    parameter int LOG2N      = FFT_LOG2N
) (
    input  logic               clk,
    input  logic               rst,
    fft_bitrev_reorder_if.slave io
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // write side
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_addr;
    logic             frame_done;

    // read FSM (issues RAM reads)
    rd_state_t        state_q, state_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_en;

    // read-issue stage, aligned with the RAM's registered output
    logic             iss_valid_q, iss_valid_d;
    logic [LOG2N-1:0] iss_index_q, iss_index_d;
    logic             iss_sof_q, iss_sof_d;

    // output registers
    logic                         out_valid_q, out_valid_d;
    logic [LOG2N-1:0]             out_index_q, out_index_d;
    logic                         out_sof_q, out_sof_d;
    logic signed [DATA_WIDTH-1:0] data_out_r_q, data_out_r_d;
    logic signed [DATA_WIDTH-1:0] data_out_i_q, data_out_i_d;

    logic [2*DATA_WIDTH-1:0]      ram_rd_data;
    logic signed [DATA_WIDTH-1:0] ram_re;
    logic signed [DATA_WIDTH-1:0] ram_im;

    fft_pingpong_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .LOG2N      (LOG2N)
    ) u_ram (
        .clk     (clk),
        .wr_en   (io.in_valid),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr),
        .wr_data ({io.data_in_r, io.data_in_i}),
        .rd_en   (rd_en),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_cnt_q),
        .rd_data (ram_rd_data)
    );

    assign ram_re = ram_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign ram_im = ram_rd_data[DATA_WIDTH-1:0];

`ifdef FFT_IFFT_SCALE_EN
    localparam logic signed [DATA_WIDTH:0] HALF =
        {{(DATA_WIDTH + 1 - LOG2N){1'b0}}, 1'b1, {(LOG2N - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = {2'b00, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = {2'b11, {(DATA_WIDTH - 1){1'b0}}};

    // One guard bit keeps x + N/2 from wrapping before the arithmetic shift.
    function automatic logic signed [DATA_WIDTH-1:0] scale_comp(
        input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH:0] t;
        t = $signed({x[DATA_WIDTH-1], x}) + HALF;
        t = t >>> LOG2N;
        if (t > SAT_MAX) begin
            t = SAT_MAX;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
        end
        return t[DATA_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [DATA_WIDTH-1:0] scale_comp(
        input logic signed [DATA_WIDTH-1:0] x);
        return x;
    endfunction
`endif

    assign wr_addr    = LOG2N'(bitrev(FFT_LOG2N'(wr_cnt_q), LOG2N));
    assign frame_done = io.in_valid && (wr_cnt_q == LAST_IDX);
    assign rd_en      = (state_q == RD_READ);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (io.in_valid) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
        end
        if (frame_done) begin
            wr_bank_d = ~wr_bank_q;
        end
    end

    // A frame completing on the last read issue restarts the burst with no gap.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        iss_valid_d = 1'b0;
        iss_index_d = iss_index_q;
        iss_sof_d   = 1'b0;
        case (state_q)
            RD_READ: begin
                iss_valid_d = 1'b1;
                iss_index_d = rd_cnt_q;
                iss_sof_d   = (rd_cnt_q == '0);
                rd_cnt_d    = rd_cnt_q + LOG2N'(1);
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
        if (frame_done) begin
            state_d   = RD_READ;
            rd_cnt_d  = '0;
            rd_bank_d = wr_bank_q;
        end
    end

    always_comb begin
        out_valid_d  = iss_valid_q;
        out_index_d  = out_index_q;
        out_sof_d    = 1'b0;
        data_out_r_d = data_out_r_q;
        data_out_i_d = data_out_i_q;
        if (iss_valid_q) begin
            out_index_d  = iss_index_q;
            out_sof_d    = iss_sof_q;
            data_out_r_d = scale_comp(ram_re);
            data_out_i_d = scale_comp(ram_im);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            state_q      <= RD_IDLE;
            rd_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            iss_valid_q  <= 1'b0;
            iss_index_q  <= '0;
            iss_sof_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_sof_q    <= 1'b0;
            data_out_r_q <= '0;
            data_out_i_q <= '0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_bank_q    <= rd_bank_d;
            iss_valid_q  <= iss_valid_d;
            iss_index_q  <= iss_index_d;
            iss_sof_q    <= iss_sof_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_sof_q    <= out_sof_d;
            data_out_r_q <= data_out_r_d;
            data_out_i_q <= data_out_i_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_index  = out_index_q;
    assign io.out_sof    = out_sof_q;
    assign io.data_out_r = data_out_r_q;
    assign io.data_out_i = data_out_i_q;
    assign io.dbg_state  = state_q;

endmodule
